// File: rtl/div_ctrl.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU; writes remainder/quotient to HI/LO.
// Optional macro DIV_EARLY_OUT_EN: skip the iterations when |dividend| < |divisor|.
module div_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             annul_i,
   input  logic             signed_i,
   input  logic [WIDTH-1:0] opdata1_i,
   input  logic [WIDTH-1:0] opdata2_i,
   output logic             stallreq_o,
   output logic             ready_o,
   output logic             hilo_we_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic [1:0]       dbg_state
);

   // Handshake: EX holds start_i until ready_o; ready_o/hilo_we_o pulse for exactly one cycle (END).
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, ZERO = 2'd1, ON = 2'd2, END = 2'd3} state_t;

   state_t           state, state_nx;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] dvd, dvs, rem, quot;
   logic             s1, s2;
   logic             accept, early_hit, take;
   logic [WIDTH-1:0] abs1, abs2, rem_sub, q_fix, r_fix;
   logic [WIDTH:0]   shifted;

   assign accept = (state == IDLE) && start_i && !annul_i;
   assign abs1   = (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
   assign abs2   = (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

`ifdef DIV_EARLY_OUT_EN
   assign early_hit = (abs1 < abs2);
`else
   assign early_hit = 1'b0;
`endif

   // One restoring step: the true difference always fits WIDTH bits when it is kept.
   assign shifted = {rem, dvd[WIDTH-1]};
   assign take    = (shifted >= {1'b0, dvs});
   assign rem_sub = shifted[WIDTH-1:0] - dvs;

   assign q_fix = (s1 ^ s2) ? -quot : quot;
   assign r_fix = s1 ? -rem : rem;

   assign hilo_we_o = ready_o;
   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      stallreq_o = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               stallreq_o = 1'b1;
               state_nx   = ((opdata2_i == '0) || early_hit) ? ZERO : ON;
            end
         end
         ZERO: begin
            stallreq_o = 1'b1;
            state_nx   = annul_i ? IDLE : END;
         end
         ON: begin
            stallreq_o = 1'b1;
            if (annul_i)                   state_nx = IDLE;
            else if (cnt == CW'(WIDTH))    state_nx = END;
         end
         END:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // ZERO doubles as the early-out finish: rem/quot are preloaded at accept.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt     <= '0;
         ready_o <= 1'b0;
         hi_o    <= '0;
         lo_o    <= '0;
         dvd     <= '0;
         dvs     <= '0;
         rem     <= '0;
         quot    <= '0;
         s1      <= 1'b0;
         s2      <= 1'b0;
      end else begin
         ready_o <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  dvd  <= abs1;
                  dvs  <= abs2;
                  rem  <= early_hit ? abs1 : '0;
                  quot <= '0;
                  s1   <= signed_i & opdata1_i[WIDTH-1];
                  s2   <= signed_i & opdata2_i[WIDTH-1];
                  cnt  <= '0;
               end
            end
            ZERO: begin
               if (!annul_i) begin
                  hi_o    <= r_fix;
                  lo_o    <= q_fix;
                  ready_o <= 1'b1;
               end
            end
            ON: begin
               if (!annul_i) begin
                  if (cnt == CW'(WIDTH)) begin
                     hi_o    <= r_fix;
                     lo_o    <= q_fix;
                     ready_o <= 1'b1;
                  end else begin
                     rem  <= take ? rem_sub : shifted[WIDTH-1:0];
                     quot <= {quot[WIDTH-2:0], take};
                     dvd  <= {dvd[WIDTH-2:0], 1'b0};
                     cnt  <= cnt + CW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_ctrl.sv
// Randomized scoreboard bench for div_ctrl against a 64-bit arithmetic reference model.
module tb_div_ctrl;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst, start_i, annul_i, signed_i;
   logic [W-1:0] opdata1_i, opdata2_i;
   logic         stallreq_o, ready_o, hilo_we_o;
   logic [W-1:0] hi_o, lo_o;
   logic [1:0]   dbg_state;

   typedef struct packed {
      logic [31:0] due;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   div_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .annul_i(annul_i), .signed_i(signed_i),
      .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .stallreq_o(stallreq_o),
      .ready_o(ready_o), .hilo_we_o(hilo_we_o), .hi_o(hi_o), .lo_o(lo_o),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Reference: truncating signed/unsigned division in 64-bit arithmetic.
   task automatic model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] hi, output logic [W-1:0] lo, output int lat);
      longint x, y, q, r, ax, ay;
      x  = sgn ? longint'($signed(a)) : longint'(a);
      y  = sgn ? longint'($signed(b)) : longint'(b);
      ax = (x < 0) ? -x : x;
      ay = (y < 0) ? -y : y;
      if (y == 0) begin
         hi = '0; lo = '0; lat = 2;
      end else begin
         q = x / y;
         r = x % y;
         lo = q[W-1:0];
         hi = r[W-1:0];
         lat = W + 2;
`ifdef DIV_EARLY_OUT_EN
         if (ax < ay) lat = 2;
`endif
      end
   endtask

   task automatic do_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] hi, lo;
      int           lat;
      bit           done, stall_ok;
      exp_t         x;
      model(sgn, a, b, hi, lo, lat);
      @(negedge clk);
      x.due = cyc + lat;
      x.hi  = hi;
      x.lo  = lo;
      exp_q.push_back(x);
      start_i = 1'b1; annul_i = 1'b0; signed_i = sgn; opdata1_i = a; opdata2_i = b;
      #1;
      done = 0; stall_ok = 1;
      for (int k = 0; k < 100 && !done; k++) begin
         if (ready_o === 1'b1) begin
            done = 1;
            if (stallreq_o !== 1'b0) stall_ok = 0;
         end else begin
            if (stallreq_o !== 1'b1) stall_ok = 0;
            @(negedge clk); #1;
         end
      end
      check("ready_timeout", done, 1);
      check("stall_profile", stall_ok, 1);
      start_i = 1'b0;
   endtask

   // Starts 50/3, then at cycle 10 either annuls or resets; no write may follow.
   task automatic abort_div(input bit use_rst, input logic [W-1:0] hi_exp, input logic [W-1:0] lo_exp);
      @(negedge clk);
      start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd3;
      repeat (10) @(negedge clk);
      if (use_rst) rst = 1'b0;
      else         annul_i = 1'b1;
      @(negedge clk);
      rst = 1'b1; annul_i = 1'b0; start_i = 1'b0;
      #1;
      check(use_rst ? "rst_stall_c11" : "annul_stall_c11", stallreq_o, 0);
      repeat (40) @(negedge clk);
      check(use_rst ? "rst_hi_hold" : "annul_hi_hold", hi_o, hi_exp);
      check(use_rst ? "rst_lo_hold" : "annul_lo_hold", lo_o, lo_exp);
   endtask

   always @(negedge clk) begin
      if (ready_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_ready", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("lo", lo_o, e.lo);
            check("hi", hi_o, e.hi);
            check("hilo_we", hilo_we_o, 1);
            check("latency", cyc, e.due);
         end
      end
   end

   initial begin
      logic [W-1:0] a, b;
      logic         sgn;
      int           sel;
      rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; signed_i = 1'b0;
      opdata1_i = '0; opdata2_i = '0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check("reset_ready", ready_o, 0);
      check("reset_we", hilo_we_o, 0);
      check("reset_hi", hi_o, 0);
      check("reset_lo", lo_o, 0);
      check("reset_stall", stallreq_o, 0);

      do_div(0, 32'd100, 32'd7);
      do_div(1, 32'hFFFF_FFF9, 32'd2);
      do_div(1, 32'd7, 32'hFFFF_FFFE);
      do_div(1, 32'h8000_0000, 32'hFFFF_FFFF);
      do_div(0, 32'hFFFF_FFFF, 32'd1);
      do_div(0, 32'd1234, 32'd0);
      do_div(1, 32'hFFFF_FF00, 32'd0);
      do_div(0, 32'd3, 32'd10);
      do_div(1, 32'hFFFF_FFFD, 32'd10);

      do_div(0, 32'd9, 32'd4);
      abort_div(1'b0, 32'd1, 32'd2);
      do_div(0, 32'd9, 32'd4);
      abort_div(1'b1, 32'd0, 32'd0);

      for (int i = 0; i < 40; i++) begin
         sgn = 1'($urandom_range(0, 1));
         sel = $urandom_range(0, 9);
         a   = $urandom;
         case (sel)
            0: b = '0;
            1: b = $urandom_range(1, 15);
            2: begin a = $urandom_range(0, 1000); b = $urandom; end
            3: b = 32'hFFFF_FFFF;
            default: b = $urandom;
         endcase
         do_div(sgn, a, b);
      end

      repeat (5) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
